// File: rtl/float_align.sv
// Block float aligner: buffers BLK single-precision operands, finds the block's max effective
// exponent, then streams two's-complement mantissas aligned to it. Build option: FLOAT_ALIGN_FTZ_EN.
module float_align #(
  parameter int BLK   = 8,
  parameter int E_W   = 8,
  parameter int M_W   = 23,
  parameter int M_X_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [E_W+M_W:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M_X_W-1:0]     out_m,
  output logic [E_W-1:0]       out_e_max,
  output logic                 out_last
);

  localparam int D_W   = 1 + E_W + M_W;
  localparam int CNT_W = (BLK > 1) ? $clog2(BLK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK - 1);
  localparam logic [31:0] M_X_W_32 = 32'(M_X_W);

  typedef enum logic {FILL, EMIT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_inc;
  logic [E_W-1:0]   max_reg, max_next, eff_in;
  logic [D_W-1:0]   buf_mem [BLK];
  logic [CNT_W-1:0] rd_idx;
  logic [D_W-1:0]   rd_word;
  logic             in_fire, out_fire, last_in;

  logic             out_valid_reg, out_last_reg;
  logic [M_X_W-1:0] out_m_reg;
  logic [E_W-1:0]   out_e_max_reg;

  function automatic logic [E_W-1:0] eff_exp(input logic [D_W-1:0] f);
    logic [E_W-1:0] e;
    e = f[D_W-2 -: E_W];
`ifdef FLOAT_ALIGN_FTZ_EN
    return e;
`else
    return (e == '0) ? E_W'(1) : e;
`endif
  endfunction

  function automatic logic [M_W:0] mag_of(input logic [D_W-1:0] f);
    logic [E_W-1:0] e;
    e = f[D_W-2 -: E_W];
`ifdef FLOAT_ALIGN_FTZ_EN
    return (e == '0) ? '0 : {1'b1, f[M_W-1:0]};
`else
    return {(e != '0), f[M_W-1:0]};
`endif
  endfunction

  // Right-shift toward the block exponent; shifts past the word width flush to zero.
  function automatic logic [M_X_W-1:0] align(input logic [D_W-1:0] f, input logic [E_W-1:0] emax);
    logic [E_W-1:0]   d;
    logic [M_X_W-1:0] a;
    d = emax - eff_exp(f);
    a = '0;
    if (32'(d) < M_X_W_32)
      a = {{(M_X_W-M_W-1){1'b0}}, mag_of(f)} >> d;
    return f[D_W-1] ? (~a + M_X_W'(1)) : a;
  endfunction

  // Handshake qualifiers and per-operand decode
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_reg && out_ready;
  assign last_in  = (cnt_reg == CNT_LAST);
  assign cnt_inc  = cnt_reg + CNT_W'(1);
  assign eff_in   = eff_exp(in_data);
  assign max_next = ((cnt_reg == '0) || (eff_in > max_reg)) ? eff_in : max_reg;

  // Element 0 is prefetched when the block completes; afterwards the next element.
  assign rd_idx  = (state_reg == FILL) ? '0 : cnt_inc;
  assign rd_word = buf_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (in_fire)
      buf_mem[cnt_reg] <= in_data;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= FILL;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL: if (in_fire && last_in)       state_next = EMIT;
      EMIT: if (out_fire && out_last_reg) state_next = FILL;
      default:                            state_next = FILL;
    endcase
  end

  // Output logic; reset is folded in so in_ready stays low while reset is held.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n && (state_reg == FILL))
      in_ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      max_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_m_reg     <= '0;
      out_e_max_reg <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (in_fire) begin
            max_reg <= max_next;
            if (last_in) begin
              cnt_reg       <= '0;
              out_valid_reg <= 1'b1;
              out_e_max_reg <= max_next;
              out_m_reg     <= align(rd_word, max_next);
              out_last_reg  <= 1'b0;
            end else begin
              cnt_reg <= cnt_inc;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (out_last_reg) begin
              cnt_reg       <= '0;
              out_valid_reg <= 1'b0;
              out_m_reg     <= '0;
              out_last_reg  <= 1'b0;
            end else begin
              cnt_reg      <= cnt_inc;
              out_m_reg    <= align(rd_word, out_e_max_reg);
              out_last_reg <= (cnt_inc == CNT_LAST);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_m     = out_m_reg;
  assign out_e_max = out_e_max_reg;
  assign out_last  = out_last_reg;

endmodule

// File: doc/float_align.md
Name: float_align

Overview:
- Front end of the dot-product datapath, performing the inverse of the normalize/repack stage.
- Collects a block of BLK IEEE-754 single-precision operands and finds the block's maximum effective exponent.
- Then streams each operand as a two's-complement fixed-point mantissa aligned to that exponent, ready for an integer accumulator.
- The accumulated sum plus out_e_max feed the downstream realign stage.

Parameters:
- BLK, 8, operands per block (power of two, >= 2).
- E_W, 8, exponent width.
- M_W, 23, stored fraction width.
- M_X_W, 32, aligned mantissa width; must be >= M_W + 2. Bits above M_W give sign and growth headroom.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data.
- in_data  input  1+E_W+M_W  float {sign, exp, frac}.
- out_valid  output  1  out_m/out_e_max/out_last valid.
- out_ready  input  1  consumer accepts output.
- out_m  output  M_X_W  aligned two's-complement mantissa.
- out_e_max  output  E_W  block max effective exponent, constant for the whole block.
- out_last  output  1  high on the final (BLK-th) output of a block.

Behaviour:
- Reset (async assert, sync release):
  - state=FILL, counters=0, running max=0.
  - in_ready=0 during reset, 1 after.
  - out_valid=0, out_m=0, out_e_max=0, out_last=0.
  - Buffer contents are don't-care.
- Decode per operand:
  - exp!=0: eff_exp=exp, mag={1,frac}.
  - exp==0: eff_exp=1, mag={0,frac}.
  - exp==all-ones has no special handling; it is treated as a normal value.
- FILL:
  - in_ready=1; a transfer occurs on in_valid&&in_ready.
  - Each accepted operand is written to buffer[cnt].
  - Running max updates: max = (cnt==0) ? eff_exp : max(max, eff_exp).
  - When the BLK-th operand is accepted, go to EMIT next cycle with cnt=0.
  - in_ready=0 for the whole of EMIT.
- EMIT:
  - out_valid=1 starting the cycle after the last input is accepted (1-cycle latency).
  - Operands are emitted in arrival order, one per out_valid&&out_ready.
  - d = out_e_max - eff_exp (unsigned, E_W bits).
  - a = (d >= M_X_W) ? 0 : (zero-extend(mag) >> d). The hidden-bit position is bit M_W when d=0; shifted-out bits are truncated, with no rounding.
  - out_m = sign ? -a : a. Negative zero yields 0.
  - out_m, out_e_max and out_last are held stable while out_valid && !out_ready.
  - out_last = 1 exactly on element BLK-1.
  - After that element transfers: out_valid=0 next cycle, state FILL, in_ready=1.
- No double buffering: throughput is BLK input cycles + BLK output cycles per block minimum.
- Simultaneous events: no input is accepted in the cycle the last output transfers; FILL resumes the following cycle.
- Reset mid-block, in FILL or EMIT:
  - The partial block is discarded and outputs return to reset values immediately.
  - The next accepted operand is element 0 of a new block.
- out_valid never drops without a transfer, except on reset.

Optional Feature:
- Macro FLOAT_ALIGN_FTZ_EN.
- Defined: operands with exp==0 use eff_exp=0 and mag=0. They contribute 0 to the max and emit out_m=0, so an all-zero/denormal block has out_e_max=0.
- Undefined: denormals are handled as in Behaviour (eff_exp=1, no hidden bit), so an all-zero block has out_e_max=1.

Test Plan:
- Basic alignment, BLK=4, inputs 0x3F800000, 0x40000000, 0xBF000000, 0x00000000:
  - out_e_max=128.
  - out_m = 0x00400000, 0x00800000, 0xFFE00000, 0x00000000.
  - out_last only on the 4th output.
- Large shift, BLK=4, inputs 0x3F800000 and three of 0x2B800000 (2^-40):
  - out_e_max=127.
  - out_m = 0x00800000 then 0x00000000 x3, since d=40 >= 32.
- Denormals, BLK=4, all 0x00000001:
  - without FTZ: out_e_max=1, out_m=0x00000001 x4.
  - with FLOAT_ALIGN_FTZ_EN: out_e_max=0, out_m=0 x4.
- Backpressure, BLK=8: hold out_ready=0 for 5 cycles on element 2.
  - out_valid and out_m are stable throughout.
  - in_ready stays 0 for the whole block.
  - All 8 outputs arrive in order with no duplicates.
- Throughput/handshake: in_valid toggling randomly across 3 back-to-back blocks.
  - Element counts are exact and out_e_max is correct per block.
  - in_ready is 1 exactly in FILL, and first out_valid comes 1 cycle after the last input is accepted.
- Reset mid-EMIT: assert rst_n=0 after 3 outputs.
  - out_valid=0 immediately and in_ready=1 after release.
  - The next block's 4 outputs are correct, with no stale data.
